// File: rtl/mpt_pkg.sv
// mpt_pkg: shared types and constants for the MPT (memory protection table)
// lookup path.
//
// Contents:
//   PLEN                 physical address width
//   mpt_access_e         access type carried by a lookup
//   mpt_permissions_e    permissions returned by a lookup
//   page_format_fault_e  fault returned by the walker (NO_ERROR when clean)
//   mpt_arb_state_e      state encoding of the walk arbiter FSM
//   mpt_gate_perm()      forces DISALLOWED whenever a fault is present
package mpt_pkg;

    localparam int PLEN = 56;

    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_READ  = 2'd1,
        ACCESS_WRITE = 2'd2,
        ACCESS_EXEC  = 2'd3
    } mpt_access_e;

    typedef enum logic [2:0] {
        DISALLOWED = 3'd0,
        ALLOW_R    = 3'd1,
        ALLOW_W    = 3'd2,
        ALLOW_RW   = 3'd3,
        ALLOW_X    = 3'd4,
        ALLOW_RX   = 3'd5,
        ALLOW_WX   = 3'd6,
        ALLOW_RWX  = 3'd7
    } mpt_permissions_e;

    typedef enum logic [1:0] {
        NO_ERROR       = 2'd0,
        NOT_VALID_ADDR = 2'd1,
        INVALID_FORMAT = 2'd2,
        RESERVED_BIT   = 2'd3
    } page_format_fault_e;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_DRAIN = 3'd4
    } mpt_arb_state_e;

    // A faulting walk never grants any permission, whatever the walker
    // reported alongside the fault.
    function automatic mpt_permissions_e mpt_gate_perm(
        input mpt_permissions_e   perm,
        input page_format_fault_e fault
    );
        return (fault != NO_ERROR) ? DISALLOWED : perm;
    endfunction

endpackage

// File: rtl/mpt_arb_grant.sv
// mpt_arb_grant: picks one requester from a valid vector.
//
// The search starts at index 'ptr' and wraps around; the first valid index
// found wins. Tying 'ptr' to zero turns this into plain lowest-index-wins
// fixed priority.
//
// Ports:
//   valid      in   NUM_REQ  requesters currently asking
//   ptr        in   IDX_W    index that has highest priority this cycle
//   grant      out  NUM_REQ  one-hot grant (all zero when nothing is valid)
//   grant_idx  out  IDX_W    binary index of the granted requester
module mpt_arb_grant #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // Walk the requesters in priority order beginning at ptr; the first
    // valid one found stops further grants via 'found'.
    always_comb begin : pick_first
        logic found;
        int   cand;
        found     = 1'b0;
        cand      = 0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mpt_walk_arbiter.sv
// mpt_walk_arbiter: shares a single MPT walker between NUM_REQ requesters.
// One lookup is outstanding at a time: accept -> issue to walker -> wait for
// completion -> one-cycle response pulse to the owning requester.
//
// Configuration macro:
//   MPT_ARB_ROUND_ROBIN_EN  defined: round-robin grant with a priority pointer
//                           undefined: fixed priority, lowest index wins
//
// Ports:
//   clk_i         in   1              clock, rising edge
//   rst_ni        in   1              asynchronous active-low reset
//   req_valid_i   in   NUM_REQ        per-requester lookup request
//   req_ready_o   out  NUM_REQ        per-requester accept (one-hot or zero)
//   req_paddr_i   in   NUM_REQ x PLEN per-requester physical address
//   req_access_i  in   NUM_REQ x acc  per-requester access type
//   rsp_valid_o   out  NUM_REQ        one-cycle response pulse to the owner
//   rsp_perm_o    out  perm           response permissions (DISALLOWED idle)
//   rsp_fault_o   out  fault          response fault (NO_ERROR idle)
//   ptw_valid_o   out  1              walk request
//   ptw_ready_i   in   1              walker accepts request
//   ptw_paddr_o   out  PLEN           walk address
//   ptw_access_o  out  acc            walk access type
//   ptw_done_i    in   1              walker completion pulse
//   ptw_perm_i    in   perm           walker result permissions
//   ptw_fault_i   in   fault          walker result fault
//   flush_i       in   1              discard the in-flight lookup
//   busy_o        out  1              high whenever not idle
module mpt_walk_arbiter
    import mpt_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PLEN    = mpt_pkg::PLEN
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0][PLEN-1:0]  req_paddr_i,
    input  mpt_access_e [NUM_REQ-1:0]     req_access_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output mpt_permissions_e              rsp_perm_o,
    output page_format_fault_e            rsp_fault_o,
    output logic                          ptw_valid_o,
    input  logic                          ptw_ready_i,
    output logic [PLEN-1:0]               ptw_paddr_o,
    output mpt_access_e                   ptw_access_o,
    input  logic                          ptw_done_i,
    input  mpt_permissions_e              ptw_perm_i,
    input  page_format_fault_e            ptw_fault_i,
    input  logic                          flush_i,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    mpt_arb_state_e     state_q, state_d;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner_q;
    logic [PLEN-1:0]    paddr_q;
    mpt_access_e        access_q;
    mpt_permissions_e   perm_q;
    page_format_fault_e fault_q;
    logic               accept;
    logic               latch_rsp;

    // Accepting is qualified with rst_ni so that req_ready_o is already low
    // while reset is held, not just once the state register has cleared.
    assign accept = (state_q == ARB_IDLE) && rst_ni && (|req_valid_i) && !flush_i;

`ifdef MPT_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    // The requester just served drops to lowest priority.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    mpt_arb_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
        .valid     (req_valid_i),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request and result registers: the walker sees a stable copy of the
    // accepted request, and the response pulse replays the latched result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            paddr_q  <= '0;
            access_q <= ACCESS_NONE;
            perm_q   <= DISALLOWED;
            fault_q  <= NO_ERROR;
        end else begin
            if (accept) begin
                owner_q  <= grant_idx;
                paddr_q  <= req_paddr_i[grant_idx];
                access_q <= req_access_i[grant_idx];
            end
            if (latch_rsp) begin
                perm_q  <= mpt_gate_perm(ptw_perm_i, ptw_fault_i);
                fault_q <= ptw_fault_i;
            end
        end
    end

    // Next-state and outputs. A flush that lands on the same cycle as the
    // walker handshake cannot recall the walk, so that case drains the
    // walker's completion instead of returning straight to idle.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        ptw_valid_o = 1'b0;
        rsp_valid_o = '0;
        rsp_perm_o  = DISALLOWED;
        rsp_fault_o = NO_ERROR;
        latch_rsp   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    req_ready_o = grant;
                    state_d     = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                ptw_valid_o = 1'b1;
                if (flush_i) begin
                    state_d = ptw_ready_i ? ARB_DRAIN : ARB_IDLE;
                end else if (ptw_ready_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (ptw_done_i) begin
                    if (flush_i) begin
                        state_d = ARB_IDLE;
                    end else begin
                        latch_rsp = 1'b1;
                        state_d   = ARB_RESP;
                    end
                end else if (flush_i) begin
                    state_d = ARB_DRAIN;
                end
            end
            ARB_RESP: begin
                rsp_valid_o[owner_q] = 1'b1;
                rsp_perm_o           = perm_q;
                rsp_fault_o          = fault_q;
                state_d              = ARB_IDLE;
            end
            ARB_DRAIN: begin
                if (ptw_done_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign ptw_paddr_o  = paddr_q;
    assign ptw_access_o = access_q;
    assign busy_o       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mpt_walk_arbiter.sv
// tb_mpt_walk_arbiter: self-checking bench for mpt_walk_arbiter.
// The bench plays the walker itself and predicts grants with a priority-list
// model: a queue of requester indices in priority order, rotated after each
// accept when the round-robin build (MPT_ARB_ROUND_ROBIN_EN) is selected.
module tb_mpt_walk_arbiter;
    import mpt_pkg::*;

    localparam int NUM_REQ = 3;

`ifdef MPT_ARB_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic                         clk_i;
    logic                         rst_ni;
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic [NUM_REQ-1:0][PLEN-1:0] req_paddr_i;
    mpt_access_e [NUM_REQ-1:0]    req_access_i;
    logic [NUM_REQ-1:0]           rsp_valid_o;
    mpt_permissions_e             rsp_perm_o;
    page_format_fault_e           rsp_fault_o;
    logic                         ptw_valid_o;
    logic                         ptw_ready_i;
    logic [PLEN-1:0]              ptw_paddr_o;
    mpt_access_e                  ptw_access_o;
    logic                         ptw_done_i;
    mpt_permissions_e             ptw_perm_i;
    page_format_fault_e           ptw_fault_i;
    logic                         flush_i;
    logic                         busy_o;

    int pass_count  = 0;
    int check_count = 0;
    int prio_q[$];

    mpt_walk_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PLEN    (PLEN)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_paddr_i  (req_paddr_i),
        .req_access_i (req_access_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_perm_o   (rsp_perm_o),
        .rsp_fault_o  (rsp_fault_o),
        .ptw_valid_o  (ptw_valid_o),
        .ptw_ready_i  (ptw_ready_i),
        .ptw_paddr_o  (ptw_paddr_o),
        .ptw_access_o (ptw_access_o),
        .ptw_done_i   (ptw_done_i),
        .ptw_perm_i   (ptw_perm_i),
        .ptw_fault_i  (ptw_fault_i),
        .flush_i      (flush_i),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic void model_reset();
        prio_q = {};
        for (int i = 0; i < NUM_REQ; i++) prio_q.push_back(i);
    endfunction

    function automatic int model_pick(input logic [NUM_REQ-1:0] valid);
        foreach (prio_q[k]) begin
            if (valid[prio_q[k]]) return prio_q[k];
        end
        return 0;
    endfunction

    // Round robin: the winner moves to the back of the priority list.
    function automatic void model_accept(input int w);
        int head;
        if (ROUND_ROBIN) begin
            while (prio_q[$] != w) begin
                head = prio_q.pop_front();
                prio_q.push_back(head);
            end
        end
    endfunction

    function automatic logic [PLEN-1:0] rand_paddr();
        return PLEN'({$urandom(), $urandom()});
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input int w);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic scramble_requests();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_paddr_i[i]  = rand_paddr();
            req_access_i[i] = mpt_access_e'($urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '1;
        flush_i     = 1'b0;
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b0;
        #1;
        checkOutput("reset_ready", req_ready_o, '0);
        checkOutput("reset_ptw_valid", ptw_valid_o, 0);
        checkOutput("reset_rsp_valid", rsp_valid_o, '0);
        checkOutput("reset_perm", rsp_perm_o, DISALLOWED);
        checkOutput("reset_fault", rsp_fault_o, NO_ERROR);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_paddr", ptw_paddr_o, '0);
        tick();
        req_valid_i = '0;
        rst_ni      = 1'b1;
        model_reset();
        tick();
    endtask

    // One complete lookup from accept to response; seen_ready returns the
    // DUT's accept vector so callers can check grant order.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] valid,
                                 input logic [NUM_REQ-1:0][PLEN-1:0] paddr,
                                 input mpt_access_e [NUM_REQ-1:0] access,
                                 input int ready_delay, input int walk_lat,
                                 input mpt_permissions_e perm,
                                 input page_format_fault_e fault,
                                 input bit flush_in_resp,
                                 output logic [NUM_REQ-1:0] seen_ready);
        int w;
        mpt_permissions_e exp_perm;
        w            = model_pick(valid);
        exp_perm     = (fault != NO_ERROR) ? DISALLOWED : perm;
        req_valid_i  = valid;
        req_paddr_i  = paddr;
        req_access_i = access;
        flush_i      = 1'b0;
        ptw_ready_i  = 1'b0;
        ptw_done_i   = 1'b0;
        #1;
        seen_ready = req_ready_o;
        checkOutput("accept_ready", req_ready_o, onehot(w));
        checkOutput("accept_idle", busy_o, 0);
        model_accept(w);
        tick();
        req_valid_i = '0;
        scramble_requests();
        for (int d = 0; d < ready_delay; d++) begin
            #1;
            checkOutput("issue_valid", ptw_valid_o, 1);
            checkOutput("issue_paddr", ptw_paddr_o, paddr[w]);
            checkOutput("issue_access", ptw_access_o, access[w]);
            checkOutput("issue_no_ready", req_ready_o, '0);
            tick();
        end
        ptw_ready_i = 1'b1;
        #1;
        checkOutput("handshake_valid", ptw_valid_o, 1);
        checkOutput("handshake_paddr", ptw_paddr_o, paddr[w]);
        tick();
        ptw_ready_i = 1'b0;
        for (int l = 0; l < walk_lat; l++) begin
            #1;
            checkOutput("wait_ptw_valid", ptw_valid_o, 0);
            checkOutput("wait_rsp", rsp_valid_o, '0);
            checkOutput("wait_busy", busy_o, 1);
            tick();
        end
        ptw_done_i  = 1'b1;
        ptw_perm_i  = perm;
        ptw_fault_i = fault;
        #1;
        checkOutput("done_rsp", rsp_valid_o, '0);
        tick();
        ptw_done_i  = 1'b0;
        ptw_perm_i  = mpt_permissions_e'($urandom_range(0, 7));
        ptw_fault_i = page_format_fault_e'($urandom_range(0, 3));
        flush_i     = flush_in_resp;
        #1;
        checkOutput("rsp_valid", rsp_valid_o, onehot(w));
        checkOutput("rsp_perm", rsp_perm_o, exp_perm);
        checkOutput("rsp_fault", rsp_fault_o, fault);
        tick();
        flush_i = 1'b0;
        #1;
        checkOutput("post_rsp_valid", rsp_valid_o, '0);
        checkOutput("post_rsp_perm", rsp_perm_o, DISALLOWED);
        checkOutput("post_rsp_fault", rsp_fault_o, NO_ERROR);
        checkOutput("post_rsp_busy", busy_o, 0);
    endtask

    // where: 0 = flush in ISSUE, 1 = flush in WAIT then done 3 cycles later,
    //        2 = flush coincident with done in WAIT
    task automatic flush_scenario(input int where);
        logic [NUM_REQ-1:0] valid;
        int w;
        valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        w     = model_pick(valid);
        scramble_requests();
        req_valid_i = valid;
        flush_i     = 1'b0;
        #1;
        checkOutput("flush_accept", req_ready_o, onehot(w));
        model_accept(w);
        tick();
        req_valid_i = '0;
        if (where == 0) begin
            flush_i = 1'b1;
            #1;
            checkOutput("flush_issue_valid", ptw_valid_o, 1);
            tick();
            flush_i = 1'b0;
            #1;
            checkOutput("flush_issue_dropped", ptw_valid_o, 0);
            checkOutput("flush_issue_idle", busy_o, 0);
        end else begin
            ptw_ready_i = 1'b1;
            #1;
            tick();
            ptw_ready_i = 1'b0;
            flush_i     = 1'b1;
            if (where == 2) ptw_done_i = 1'b1;
            ptw_perm_i = ALLOW_RWX;
            #1;
            checkOutput("flush_wait_busy", busy_o, 1);
            tick();
            flush_i    = 1'b0;
            ptw_done_i = 1'b0;
            if (where == 1) begin
                for (int c = 0; c < 2; c++) begin
                    #1;
                    checkOutput("drain_busy", busy_o, 1);
                    checkOutput("drain_rsp", rsp_valid_o, '0);
                    tick();
                end
                ptw_done_i = 1'b1;
                #1;
                checkOutput("drain_done_busy", busy_o, 1);
                tick();
                ptw_done_i = 1'b0;
            end
            #1;
            checkOutput("flush_wait_idle", busy_o, 0);
            checkOutput("flush_wait_no_rsp", rsp_valid_o, '0);
        end
        tick();
        checkOutput("flush_no_late_rsp", rsp_valid_o, '0);
    endtask

    task automatic random_lookup();
        logic [NUM_REQ-1:0]           valid;
        logic [NUM_REQ-1:0][PLEN-1:0] paddr;
        mpt_access_e [NUM_REQ-1:0]    access;
        logic [NUM_REQ-1:0]           seen;
        page_format_fault_e           fault;
        valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        for (int i = 0; i < NUM_REQ; i++) begin
            paddr[i]  = rand_paddr();
            access[i] = mpt_access_e'($urandom_range(0, 3));
        end
        fault = ($urandom_range(0, 1) == 0) ? NO_ERROR
                                            : page_format_fault_e'($urandom_range(0, 3));
        applyStimulus(valid, paddr, access, $urandom_range(0, 3), $urandom_range(0, 3),
                      mpt_permissions_e'($urandom_range(0, 7)), fault,
                      1'($urandom_range(0, 1)), seen);
    endtask

    initial begin : stimulus
        logic [NUM_REQ-1:0][PLEN-1:0] paddr;
        mpt_access_e [NUM_REQ-1:0]    access;
        logic [NUM_REQ-1:0]           seen;
        int                           exp_order[4];

        rst_ni      = 1'b1;
        req_valid_i = '0;
        req_paddr_i = '0;
        req_access_i = '{default: ACCESS_NONE};
        ptw_ready_i = 1'b0;
        ptw_done_i  = 1'b0;
        ptw_perm_i  = DISALLOWED;
        ptw_fault_i = NO_ERROR;
        flush_i     = 1'b0;
        #1;
        do_reset();

        // Two simultaneous requests, walker ready at once, done 2 cycles later.
        paddr     = '0;
        paddr[0]  = PLEN'(64'h1000);
        paddr[1]  = PLEN'(64'h2000);
        access[0] = ACCESS_READ;
        access[1] = ACCESS_WRITE;
        access[2] = ACCESS_NONE;
        applyStimulus(3'b011, paddr, access, 0, 2, ALLOW_RW, NO_ERROR, 1'b0, seen);
        checkOutput("both_valid_first", seen, 3'b001);
        applyStimulus(3'b010, paddr, access, 0, 2, ALLOW_RW, NO_ERROR, 1'b0, seen);
        checkOutput("both_valid_second", seen, 3'b010);

        // Grant order with requesters 0 and 1 always asking.
        do_reset();
        exp_order = ROUND_ROBIN ? '{0, 1, 0, 1} : '{0, 0, 0, 0};
        for (int n = 0; n < 4; n++) begin
            applyStimulus(3'b011, paddr, access, 0, 1, ALLOW_R, NO_ERROR, 1'b0, seen);
            checkOutput($sformatf("grant_order_%0d", n), seen, onehot(exp_order[n]));
        end

        // Walker stalls the handshake for 5 cycles.
        applyStimulus(3'b100, paddr, access, 5, 0, ALLOW_RX, NO_ERROR, 1'b0, seen);

        // Fault forces DISALLOWED even though the walker reported ALLOW_RWX.
        applyStimulus(3'b001, paddr, access, 0, 0, ALLOW_RWX, NOT_VALID_ADDR, 1'b0, seen);

        // Flush during the response pulse does not cut it short.
        applyStimulus(3'b110, paddr, access, 1, 1, ALLOW_W, NO_ERROR, 1'b1, seen);

        flush_scenario(0);
        flush_scenario(1);
        flush_scenario(2);

        // Reset while waiting on the walker abandons the lookup.
        req_valid_i = 3'b010;
        scramble_requests();
        #1;
        checkOutput("rst_wait_accept", req_ready_o, onehot(model_pick(3'b010)));
        tick();
        req_valid_i = '0;
        ptw_ready_i = 1'b1;
        #1;
        tick();
        ptw_ready_i = 1'b0;
        #1;
        checkOutput("rst_wait_busy", busy_o, 1);
        rst_ni      = 1'b0;
        req_valid_i = '1;
        #1;
        checkOutput("rst_wait_busy_cleared", busy_o, 0);
        checkOutput("rst_wait_ptw_valid", ptw_valid_o, 0);
        checkOutput("rst_wait_ready", req_ready_o, '0);
        checkOutput("rst_wait_paddr", ptw_paddr_o, '0);
        checkOutput("rst_wait_perm", rsp_perm_o, DISALLOWED);
        tick();
        req_valid_i = '0;
        rst_ni      = 1'b1;
        model_reset();
        ptw_done_i  = 1'b1;
        ptw_perm_i  = ALLOW_RWX;
        #1;
        tick();
        ptw_done_i = 1'b0;
        #1;
        checkOutput("rst_release_no_rsp", rsp_valid_o, '0);
        checkOutput("rst_release_idle", busy_o, 0);
        tick();
        checkOutput("rst_release_no_late_rsp", rsp_valid_o, '0);

        for (int n = 0; n < 40; n++) begin
            random_lookup();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mpt_walk_arbiter.md
MPT_WALK_ARBITER -- requirements
Module: mpt_walk_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter PLEN, default mpt_pkg::PLEN, physical address width.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester lookup request.
REQ-006 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 SHALL have port req_paddr_i  input  NUM_REQ x PLEN  per-requester physical address.
REQ-008 SHALL have port req_access_i  input  NUM_REQ x mpt_access_e  per-requester access type.
REQ-009 SHALL have port rsp_valid_o  output  NUM_REQ  one-cycle response pulse to the owning requester.
REQ-010 SHALL have port rsp_perm_o  output  mpt_permissions_e  shared response permissions.
REQ-011 SHALL have port rsp_fault_o  output  page_format_fault_e  shared response fault code.
REQ-012 SHALL have port ptw_valid_o  output  1  walk request to the MPT walker.
REQ-013 SHALL have port ptw_ready_i  input  1  walker accepts request.
REQ-014 SHALL have port ptw_paddr_o  output  PLEN  address for the walker.
REQ-015 SHALL have port ptw_access_o  output  mpt_access_e  access type for the walker.
REQ-016 SHALL have port ptw_done_i  input  1  walker completion pulse.
REQ-017 SHALL have port ptw_perm_i  input  mpt_permissions_e  walker result.
REQ-018 SHALL have port ptw_fault_i  input  page_format_fault_e  walker fault (NO_ERROR if none).
REQ-019 SHALL have port flush_i  input  1  discard in-flight lookup.
REQ-020 SHALL have port busy_o  output  1  high whenever state is not ARB_IDLE.

Function
REQ-021 SHALL implement FSM ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP, ARB_DRAIN.
REQ-022 ARB_IDLE: req_ready_o[g] SHALL be combinationally high for granted index g when any req_valid_i set and flush_i low; on that cycle register g, paddr, access; go ARB_ISSUE.
REQ-023 ARB_ISSUE: ptw_valid_o high with registered paddr/access, held stable until ptw_ready_i; on ptw_ready_i go ARB_WAIT.
REQ-024 ARB_WAIT: on ptw_done_i latch ptw_perm_i/ptw_fault_i and go ARB_RESP.
REQ-025 ARB_RESP: rsp_valid_o[g] high exactly one cycle with latched perm/fault; then ARB_IDLE.
REQ-026 Minimum accept-to-response latency SHALL be 3 cycles plus walker latency; one lookup outstanding at a time.
REQ-027 flush_i in ARB_ISSUE before handshake SHALL drop ptw_valid_o next cycle and return to ARB_IDLE with no response.
REQ-028 flush_i in ARB_WAIT SHALL go ARB_DRAIN; ARB_DRAIN waits for ptw_done_i, suppresses response, returns ARB_IDLE.
REQ-029 flush_i coincident with ptw_done_i in ARB_WAIT SHALL suppress the response and go ARB_IDLE.
REQ-030 flush_i in ARB_RESP SHALL not suppress the pulse already in progress.
REQ-031 rsp_perm_o/rsp_fault_o SHALL be DISALLOWED/NO_ERROR whenever rsp_valid_o is zero.
REQ-032 ptw_fault_i != NO_ERROR SHALL force rsp_perm_o DISALLOWED.

Reset
REQ-033 On rst_ni low: state ARB_IDLE, all outputs 0, rsp_perm_o DISALLOWED, rsp_fault_o NO_ERROR, priority pointer 0.
REQ-034 Reset mid-lookup SHALL abandon the lookup with no response after release.

Configuration
REQ-035 With MPT_ARB_ROUND_ROBIN_EN defined: grant = first valid index at or after pointer (wrapping); pointer = g+1 mod NUM_REQ on accept.
REQ-036 Without MPT_ARB_ROUND_ROBIN_EN: fixed priority, lowest valid index wins; no pointer register.

Structure
REQ-037 mpt_arb_state_e SHALL be added to mpt_pkg; mpt_access_e, mpt_permissions_e, page_format_fault_e, PLEN taken from mpt_pkg.
REQ-038 Grant logic SHALL be sub-module mpt_arb_grant (valid vector, pointer in; one-hot grant, index out).

Verification
REQ-039 req_valid_i=2'b11, paddr0=0x1000, paddr1=0x2000, walker ready, done 2 cycles later with ALLOW_RW -> requester 0 served first, rsp_valid_o=2'b01 with ALLOW_RW; then requester 1 served.
REQ-040 RR build, both requesters held valid for 4 lookups -> grant order 0,1,0,1; fixed build -> 0,0,0,0.
REQ-041 ptw_ready_i low 5 cycles in ARB_ISSUE -> ptw_valid_o and ptw_paddr_o stable all 5 cycles.
REQ-042 flush_i in ARB_WAIT, ptw_done_i 3 cycles later -> no rsp_valid_o, busy_o drops cycle after done.
REQ-043 ptw_fault_i=NOT_VALID_ADDR with ptw_perm_i=ALLOW_RWX -> rsp_fault_o NOT_VALID_ADDR, rsp_perm_o DISALLOWED.
REQ-044 rst_ni low during ARB_WAIT -> outputs to reset values immediately, no response after release.
